dma_desc_writeback: RTL and testbench

Descriptor write-back engine for the DMA. It pops completion entries produced by the data mover, then writes the final transfer length and status back into the in-memory descriptor over a 2-beat Avalon-MM burst write. The status word it writes has owned_by_hw cleared, which hands the descriptor back to software. It is the writer counterpart of the descriptor fetch engine: it writes words 6-7 of the same 8-word (256-bit) descriptor that the fetch engine reads.

---
 rtl/dma_desc_writeback_if.sv | 46 ++++
 rtl/dma_desc_writeback.sv | 155 +++++++++++++++
 tb/tb_dma_desc_writeback.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_desc_writeback_if.sv
// Purpose: bundles the completion-FIFO pop port and the Avalon-MM descriptor write-back port.
// Latency: none (wires only).
// Backpressure: FIFO side is pop-on-demand gated by empty; Avalon side stalls on waitrequest.
//
// Signals:
//   dma_wb_fifo_empty_i       completion FIFO empty
//   dma_wb_fifo_rd_o          completion FIFO pop (one-cycle pulse)
//   dma_wb_fifo_rddata_i      {status, actual_len, desc_addr}, valid the cycle after a pop
//   dma_desc_wb_write_o       Avalon write
//   dma_desc_wb_bcount_o      Avalon burstcount
//   dma_desc_wb_addr_o        Avalon byte address
//   dma_desc_wb_wrdata_o      Avalon write data
//   dma_desc_wb_waitrequest_i Avalon waitrequest
// Modports: master = write-back engine, slave = FIFO + memory side.
interface dma_desc_writeback_if;
    logic        dma_wb_fifo_empty_i;
    logic        dma_wb_fifo_rd_o;
    logic [95:0] dma_wb_fifo_rddata_i;
    logic        dma_desc_wb_write_o;
    logic [3:0]  dma_desc_wb_bcount_o;
    logic [31:0] dma_desc_wb_addr_o;
    logic [31:0] dma_desc_wb_wrdata_o;
    logic        dma_desc_wb_waitrequest_i;

    modport master (
        input  dma_wb_fifo_empty_i,
        input  dma_wb_fifo_rddata_i,
        input  dma_desc_wb_waitrequest_i,
        output dma_wb_fifo_rd_o,
        output dma_desc_wb_write_o,
        output dma_desc_wb_bcount_o,
        output dma_desc_wb_addr_o,
        output dma_desc_wb_wrdata_o
    );

    modport slave (
        output dma_wb_fifo_empty_i,
        output dma_wb_fifo_rddata_i,
        output dma_desc_wb_waitrequest_i,
        input  dma_wb_fifo_rd_o,
        input  dma_desc_wb_write_o,
        input  dma_desc_wb_bcount_o,
        input  dma_desc_wb_addr_o,
        input  dma_desc_wb_wrdata_o
    );
endinterface

// File: rtl/dma_desc_writeback.sv
// Purpose: pops DMA completion entries and writes {actual_len, status} back into descriptor words 6-7.
// Latency: 5 cycles per descriptor with no waitrequest (POP, LATCH, BEAT0, BEAT1, DONE), one per 6 sustained.
// Backpressure: each Avalon beat holds while waitrequest=1; run=0 only blocks new pops, never aborts a burst.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   csr_control_i      bit0 run, bit1 irq_en, bit2 clr_count
//   bus                FIFO pop port and Avalon-MM burst write port (master modport)
//   dma_desc_wb_irq_o  one-cycle completion interrupt (during DONE)
//   dma_desc_wb_count_o number of descriptors written back, wraps, clearable
//   dma_desc_wb_busy_o high whenever the engine is not idle
module dma_desc_writeback #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          csr_control_i,
    dma_desc_writeback_if.master bus,
    output logic                 dma_desc_wb_irq_o,
    output logic [CNT_W-1:0]     dma_desc_wb_count_o,
    output logic                 dma_desc_wb_busy_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LATCH = 3'd2,
        S_BEAT0 = 3'd3,
        S_BEAT1 = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Status word bit positions
    localparam int IRQ_ON_DONE_BIT = 24;

    state_t      state;
    logic [31:0] addr_r;
    logic [29:0] stat_r;

    logic        run;
    logic        irq_en;
    logic        clr_count;
    logic [31:0] desc_addr_in;
    logic [31:0] wb_addr_in;
    logic [31:0] stat_wb;

    assign run       = csr_control_i[0];
    assign irq_en    = csr_control_i[1];
    assign clr_count = csr_control_i[2];

    // Descriptors are 32-byte aligned; the low address bits carried in the
    // completion entry are ignored. Word 6 sits at byte offset 24.
    assign desc_addr_in = bus.dma_wb_fifo_rddata_i[31:0];
    assign wb_addr_in   = {desc_addr_in[31:5], 5'b0} + 32'd24;

    // Status handed back to software: owned_by_hw cleared, done set,
    // everything else passed through from the data mover.
    assign stat_wb = {1'b0, 1'b1, stat_r};

    // The Avalon address is simply the latched descriptor word-6 address; it
    // holds between bursts.
    assign bus.dma_desc_wb_addr_o = addr_r;

    // Bits of the CSR and completion entry this block has no use for.
    logic unused_bits;
    assign unused_bits = ^{csr_control_i[31:3],
                           bus.dma_wb_fifo_rddata_i[95:94],
                           desc_addr_in[4:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state                    <= S_IDLE;
            addr_r                   <= '0;
            stat_r                   <= '0;
            bus.dma_wb_fifo_rd_o     <= 1'b0;
            bus.dma_desc_wb_write_o  <= 1'b0;
            bus.dma_desc_wb_bcount_o <= 4'd0;
            bus.dma_desc_wb_wrdata_o <= '0;
            dma_desc_wb_irq_o        <= 1'b0;
            dma_desc_wb_count_o      <= '0;
            dma_desc_wb_busy_o       <= 1'b0;
        end else begin
            // Pulsed outputs default low; they are only raised for the
            // single cycle they belong to.
            bus.dma_wb_fifo_rd_o <= 1'b0;
            dma_desc_wb_irq_o    <= 1'b0;

            case (state)
                S_IDLE: begin
                    // run is only honoured here, so dropping it never cuts a
                    // burst short.
                    if (run && !bus.dma_wb_fifo_empty_i) begin
                        state                <= S_POP;
                        bus.dma_wb_fifo_rd_o <= 1'b1;
                        dma_desc_wb_busy_o   <= 1'b1;
                    end
                end

                S_POP: begin
                    state <= S_LATCH;
                end

                S_LATCH: begin
                    // FIFO read data is valid now, one cycle after the pop.
                    // The length goes straight into the beat-0 data register.
                    addr_r                   <= wb_addr_in;
                    stat_r                   <= bus.dma_wb_fifo_rddata_i[93:64];
                    bus.dma_desc_wb_write_o  <= 1'b1;
                    bus.dma_desc_wb_bcount_o <= 4'd2;
                    bus.dma_desc_wb_wrdata_o <= bus.dma_wb_fifo_rddata_i[63:32];
                    state                    <= S_BEAT0;
                end

                S_BEAT0: begin
                    if (!bus.dma_desc_wb_waitrequest_i) begin
                        bus.dma_desc_wb_wrdata_o <= stat_wb;
                        state                    <= S_BEAT1;
                    end
                end

                S_BEAT1: begin
                    if (!bus.dma_desc_wb_waitrequest_i) begin
                        bus.dma_desc_wb_write_o  <= 1'b0;
                        bus.dma_desc_wb_bcount_o <= 4'd0;
                        bus.dma_desc_wb_wrdata_o <= '0;
                        // irq is registered so it lines up exactly with DONE.
                        dma_desc_wb_irq_o        <= stat_r[IRQ_ON_DONE_BIT] && irq_en;
                        state                    <= S_DONE;
                    end
                end

                S_DONE: begin
                    dma_desc_wb_count_o <= dma_desc_wb_count_o + CNT_W'(1);
                    dma_desc_wb_busy_o  <= 1'b0;
                    state               <= S_IDLE;
                end

                default: begin
                    bus.dma_desc_wb_write_o  <= 1'b0;
                    bus.dma_desc_wb_bcount_o <= 4'd0;
                    bus.dma_desc_wb_wrdata_o <= '0;
                    dma_desc_wb_busy_o       <= 1'b0;
                    state                    <= S_IDLE;
                end
            endcase

            // Placed after the state case so a clear in the DONE cycle
            // overrides the increment.
            if (clr_count) begin
                dma_desc_wb_count_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dma_desc_writeback.sv
// Purpose: randomized self-checking bench for dma_desc_writeback against a transaction-level model.
// Latency: model expects beats in order, irq in the cycle after the last beat is accepted.
// Backpressure: waitrequest is driven by selectable patterns (none, random, scripted stretch, stall beat 1).
module tb_dma_desc_writeback;
    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      csr_control;
    logic             irq;
    logic [CNT_W-1:0] count;
    logic             busy;

    dma_desc_writeback_if bus_if();

    dma_desc_writeback #(.CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .csr_control_i       (csr_control),
        .bus                 (bus_if),
        .dma_desc_wb_irq_o   (irq),
        .dma_desc_wb_count_o (count),
        .dma_desc_wb_busy_o  (busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
        logic        irq;
    } beat_t;

    logic [95:0] fifo_q[$];
    beat_t       exp_q[$];
    int          rd_times[$];
    int          tests = 0;
    int          fails = 0;
    int          model_count = 0;
    int          irq_cnt = 0;
    int          rd_cnt = 0;
    int          beats_acc = 0;
    int          cyc = 0;
    int          wait_mode = 0;   // 0 none, 1 random, 2 stretch 3/2, 3 stall beat 1

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] make_entry(input logic irq_bit);
        logic [31:0] st;
        logic [31:0] len;
        logic [31:0] adr;
        st      = $urandom;
        st[24]  = irq_bit;
        len     = $urandom;
        adr     = $urandom;
        return {st, len, adr};
    endfunction

    // Memory-side model: FIFO, waitrequest driver and beat/irq/count scoreboard.
    initial begin
        logic        prev_write, prev_accept, prev_stall, prev_rd, irq_pend, inc_pend;
        logic        w, accept, new_beat;
        logic [31:0] p_addr, p_data;
        logic [3:0]  p_bc;
        logic [95:0] ent;
        int          cib;
        beat_t       e;
        beat_t       b;
        prev_write = 0; prev_accept = 0; prev_stall = 0; prev_rd = 0;
        irq_pend = 0; inc_pend = 0; cib = 0;
        p_addr = 0; p_data = 0; p_bc = 0;
        bus_if.dma_wb_fifo_empty_i       = 1'b1;
        bus_if.dma_desc_wb_waitrequest_i = 1'b0;
        bus_if.dma_wb_fifo_rddata_i      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                exp_q.delete();
                model_count = 0;
                prev_write = 0; prev_accept = 0; prev_stall = 0;
                irq_pend = 0; inc_pend = 0; cib = 0;
                bus_if.dma_desc_wb_waitrequest_i = 1'b0;
            end else begin
                check("irq", irq, irq_pend);
                if (irq) irq_cnt++;
                irq_pend = 0;
                if (inc_pend) model_count = (model_count + 1) % CNT_MOD;
                inc_pend = 0;
                if (csr_control[2]) model_count = 0;

                if (prev_stall) begin
                    check("stall_addr", bus_if.dma_desc_wb_addr_o, p_addr);
                    check("stall_data", bus_if.dma_desc_wb_wrdata_o, p_data);
                    check("stall_bcount", bus_if.dma_desc_wb_bcount_o, p_bc);
                end

                if (!bus_if.dma_desc_wb_write_o) begin
                    check("idle_bcount", bus_if.dma_desc_wb_bcount_o, 0);
                    check("idle_wrdata", bus_if.dma_desc_wb_wrdata_o, 0);
                end else begin
                    check("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q[0];
                        check("beat_addr", bus_if.dma_desc_wb_addr_o, e.addr);
                        check("beat_data", bus_if.dma_desc_wb_wrdata_o, e.data);
                        check("beat_bcount", bus_if.dma_desc_wb_bcount_o, 2);
                    end
                end

                new_beat = bus_if.dma_desc_wb_write_o && (!prev_write || prev_accept);
                if (new_beat) cib = 0;
                else if (bus_if.dma_desc_wb_write_o) cib++;
                e = (exp_q.size() != 0) ? exp_q[0] : '0;
                case (wait_mode)
                    1:       w = ($urandom_range(0, 3) == 0);
                    2:       w = (cib < (e.last ? 2 : 3));
                    3:       w = e.last;
                    default: w = 1'b0;
                endcase
                bus_if.dma_desc_wb_waitrequest_i = bus_if.dma_desc_wb_write_o && w;
                accept = bus_if.dma_desc_wb_write_o && !w;
                if (accept && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    beats_acc++;
                    if (e.last) begin
                        irq_pend = e.irq;
                        inc_pend = 1'b1;
                    end
                end
                prev_stall  = bus_if.dma_desc_wb_write_o && w;
                p_addr      = bus_if.dma_desc_wb_addr_o;
                p_data      = bus_if.dma_desc_wb_wrdata_o;
                p_bc        = bus_if.dma_desc_wb_bcount_o;
                prev_write  = bus_if.dma_desc_wb_write_o;
                prev_accept = accept;
            end

            // Completion FIFO: data appears the cycle after the pop and stays
            // through that cycle; garbage otherwise.
            if (bus_if.dma_wb_fifo_rd_o) begin
                check("rd_single_pulse", prev_rd, 0);
                check("pop_nonempty", fifo_q.size() != 0, 1);
                rd_cnt++;
                rd_times.push_back(cyc);
                if (fifo_q.size() != 0) begin
                    ent = fifo_q.pop_front();
                    bus_if.dma_wb_fifo_rddata_i = ent;
                    b.addr = {ent[31:5], 5'b0} + 32'd24;
                    b.data = ent[63:32];
                    b.last = 1'b0;
                    b.irq  = 1'b0;
                    exp_q.push_back(b);
                    b.data = {2'b01, ent[93:64]};
                    b.last = 1'b1;
                    b.irq  = ent[88] && csr_control[1];
                    exp_q.push_back(b);
                end
            end else if (!prev_rd) begin
                bus_if.dma_wb_fifo_rddata_i = {$urandom, $urandom, $urandom};
            end
            prev_rd = bus_if.dma_wb_fifo_rd_o;
            bus_if.dma_wb_fifo_empty_i = (fifo_q.size() == 0);
        end
    end

    task automatic wait_idle(output int busy_n);
        busy_n = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (busy) busy_n++;
            else if (fifo_q.size() == 0 || !csr_control[0]) break;
        end
        check("idle_reached", busy, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, i0, r0, b0, n0, exp_irq;
        logic [95:0] ent;
        reset = 1'b1;
        csr_control = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd", bus_if.dma_wb_fifo_rd_o, 0);
        check("rst_write", bus_if.dma_desc_wb_write_o, 0);
        check("rst_bcount", bus_if.dma_desc_wb_bcount_o, 0);
        check("rst_addr", bus_if.dma_desc_wb_addr_o, 0);
        check("rst_wrdata", bus_if.dma_desc_wb_wrdata_o, 0);
        check("rst_irq", irq, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        csr_control = 32'h3;

        // Single directed entry, irq enabled, no wait.
        i0 = irq_cnt;
        fifo_q.push_back({32'h81000010, 32'h00000400, 32'h10000047});
        wait_idle(nb);
        check("t1_busy_cycles", nb, 5);
        check("t1_count", count, 1);
        check("t1_irq_pulses", irq_cnt - i0, 1);

        // Waitrequest stretch: 3 stall cycles on beat 0, 2 on beat 1.
        wait_mode = 2;
        b0 = beats_acc;
        fifo_q.push_back(make_entry(1'b0));
        wait_idle(nb);
        check("t2_beats", beats_acc - b0, 2);
        check("t2_busy_cycles", nb, 10);
        check("t2_count", count, model_count);
        check("t2_count_abs", count, 2);

        // Back-to-back, irq_on_done clear.
        wait_mode = 0;
        i0 = irq_cnt;
        n0 = rd_times.size();
        for (int k = 0; k < 3; k++) fifo_q.push_back(make_entry(1'b0));
        wait_idle(nb);
        check("t3_pops", rd_times.size() - n0, 3);
        if (rd_times.size() - n0 == 3) begin
            check("t3_spacing01", rd_times[n0+1] - rd_times[n0], 6);
            check("t3_spacing12", rd_times[n0+2] - rd_times[n0+1], 6);
        end
        check("t3_irq_none", irq_cnt - i0, 0);
        check("t3_count", count, 5);

        // Run dropped during beat 0 with two entries queued.
        r0 = rd_cnt;
        fifo_q.push_back(make_entry(1'b1));
        fifo_q.push_back(make_entry(1'b1));
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (bus_if.dma_desc_wb_write_o) break;
        end
        check("t4_in_beat0", bus_if.dma_desc_wb_write_o, 1);
        csr_control = 32'h2;
        wait_idle(nb);
        repeat (10) @(posedge clk);
        #1;
        check("t4_pops", rd_cnt - r0, 1);
        check("t4_left_in_fifo", fifo_q.size(), 1);
        check("t4_busy", busy, 0);
        check("t4_count", count, 6);
        fifo_q.delete();
        repeat (2) @(posedge clk);
        #1;
        csr_control = 32'h3;

        // Reset while beat 1 is stalled.
        wait_mode = 3;
        r0 = rd_cnt;
        fifo_q.push_back({32'h01000000, 32'h00000100, $urandom});
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (bus_if.dma_desc_wb_write_o && bus_if.dma_desc_wb_wrdata_o[30]) break;
        end
        check("t5_in_beat1", bus_if.dma_desc_wb_write_o && bus_if.dma_desc_wb_wrdata_o[30], 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_write", bus_if.dma_desc_wb_write_o, 0);
        check("t5_bcount", bus_if.dma_desc_wb_bcount_o, 0);
        check("t5_count", count, 0);
        check("t5_busy", busy, 0);
        check("t5_rd", bus_if.dma_wb_fifo_rd_o, 0);
        check("t5_irq", irq, 0);
        reset = 1'b0;
        wait_mode = 0;
        @(posedge clk); #1;
        check("t5_no_pop", rd_cnt - r0, 1);

        // Counter wrap with random data and random waitrequest.
        wait_mode = 1;
        for (int k = 0; k < 15; k++) fifo_q.push_back(make_entry($urandom_range(0, 1)));
        wait_idle(nb);
        check("t6_count15", count, 15);
        fifo_q.push_back(make_entry($urandom_range(0, 1)));
        wait_idle(nb);
        check("t6_wrap", count, 0);
        check("t6_model", count, model_count);

        // clr_count in the DONE cycle.
        wait_mode = 0;
        fifo_q.push_back(make_entry(1'b1));
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (irq) break;
        end
        check("t6_done_seen", irq, 1);
        csr_control = 32'h7;
        @(posedge clk); #1;
        csr_control = 32'h3;
        wait_idle(nb);
        check("t6_clr_collide", count, 0);

        // Random soak with irq enabled.
        wait_mode = 1;
        i0 = irq_cnt;
        exp_irq = 0;
        for (int k = 0; k < 20; k++) begin
            ent = make_entry($urandom_range(0, 1));
            if (ent[88]) exp_irq++;
            fifo_q.push_back(ent);
        end
        wait_idle(nb);
        check("t7_count", count, model_count);
        check("t7_count_abs", count, 20 % CNT_MOD);
        check("t7_irq_pulses", irq_cnt - i0, exp_irq);
        check("t7_beats_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
